fft_stage4: RTL and testbench
=============================

// Module: fft_stage4
// PURPOSE
//  Fourth radix-2 SDF (single-path delay feedback) stage of the 32-point pipelined DIF FFT.
//  Consumes the 16-bit stream produced by STAGE3 and emits a 17-bit stream to STAGE5.
//  Contains:
//   - a 2-deep feedback delay line
//   - a butterfly with span 2
//   - trivial W4 twiddle rotation (1 or -j), so no multiplier is needed.
//  Processes one complex sample per clock; frames of 32 samples; natural-in, DIF-order-out.
// PARAMETERS
//  IN_W   16  input word width per real/imag component (two's complement)
//  OUT_W  17  output word width per component (IN_W+1, one bit growth)
//  DLY    2   feedback delay depth = butterfly span (fixed for stage 4; not to be overridden)
//  N      32  FFT frame length
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  valid_i     in   1      input sample qualifier; frame-contiguous (32 consecutive cycles per frame)
//  data_in_r   in   IN_W   input real part, signed
//  data_in_i   in   IN_W   input imag part, signed
//  valid_o     out  1      output sample qualifier
//  data_out_r  out  OUT_W  output real part, signed, registered
//  data_out_i  out  OUT_W  output imag part, signed, registered
// BEHAVIOUR
//  Reset (rst high at posedge):
//   - valid_o=0, data_out_r/i=0, sample counter cnt=0, flush counter=0, delay line cleared to 0.
//   - Reset overrides everything, including mid-frame; the frame in progress is discarded, with no
//     partial-output tail.
//  run = valid_i | (flush!=0). cnt[4:0] increments on every posedge with run=1 and wraps 31->0.
//  phase = cnt[1]:
//   - phase 0 (cnt[1:0]=00,01):
//     - push input (sign-extended to OUT_W) into the delay line.
//     - output = delay head, which holds the difference from the previous group.
//     - if cnt[1:0]==01, rotate the output by -j: (a+jb)*(-j) -> re=b, im=-a.
//   - phase 1 (cnt[1:0]=10,11):
//     - output = head + in (sum).
//     - push head - in (difference) into the delay line.
//  Arithmetic:
//   - operands sign-extended to OUT_W before add/sub; no rounding, no saturation.
//   - negation in the -j rotation cannot overflow, because |diff| <= 2^16-1.
//  Latency: sample k sampled at edge k -> its sum term on data_out at edge k+DLY.
//   - valid_o rises exactly 2 cycles after the first valid_i sample.
//   - output order per 4-group: sum0, sum1, diff0, diff1*(-j).
//  Flush: when valid_i falls, flush=DLY is loaded.
//   - The block runs with zero input for 2 more cycles to drain the last two differences.
//   - valid_o therefore stays high for exactly 32*F cycles for F back-to-back frames.
//  valid_o is high iff a run cycle at least DLY cycles after stream start produced a result.
//   - Implemented as a 2-stage shift of run, gated on stream-start.
//  Back-to-back frames (valid_i never drops): seamless. Phase-0 pushes of frame f+1 coincide with
//  draining frame f; no bubble.
//  valid_i dropping mid-frame (cnt!=0): protocol error.
//   - The block flushes 2 cycles, then clears cnt to 0.
//   - Output data during that window is don't-care; valid_o timing still follows the rule above.
//  valid_i re-asserted during flush: treated as a new stream and cnt continues.
//   - A frame must not start during flush; the bench never does this.
// STRUCTURE
//  fft_defs.vh (shared `include): FFT_N=32, per-stage widths (S3_OUT_W=16, S4_OUT_W=17, ...),
//   and stage delay depths.
//  Sub-module fft_bf2: combinational radix-2 butterfly (sum/diff, sign-extension). Reused by
//   STAGE1..5.
//  fft_stage4 holds:
//   - the delay-line registers (2 x 2 x OUT_W)
//   - cnt, flush counter, valid shift register
//   - the -j rotate mux and the output registers.
// TESTING
//  Reset: rst=1 for 2 cycles mid-idle -> valid_o=0, data_out_r=data_out_i=0 on next cycle.
//  Impulse: x[0]=1+j0, x[1..31]=0 -> outputs 0..31: re = 1,0,1,0,0...; im all 0; valid_o high
//   exactly 32 cycles.
//  Ramp: x[k]=k+j0 -> group 0 outputs: (2,0),(4,0),(-2,0),(0,2); group 1 (x=4..7): (10,0),(12,0),
//   (-2,0),(0,2).
//  Width extremes: all x=32767-j32768 -> sums re=65534, im=-65536; diffs 0; no wrap; sign bits
//   correct.
//  Back-to-back: 2 frames, 64 contiguous valid_i -> valid_o 64 contiguous cycles starting 2 after
//   first input; frame 2 output equals frame 2 run standalone.
//  Mid-frame reset: rst=1 at sample 10 -> next cycle valid_o=0, outputs 0; following impulse frame
//   matches the impulse golden.

Source files
------------

// File: rtl/fft_stage4_pkg.sv
// Shared constants and types for stage 4 of the 32-point SDF DIF FFT.
package fft_stage4_pkg;

  // Frame length and per-stage component widths.
  localparam int FFT_N    = 32;
  localparam int S3_OUT_W = 16;
  localparam int S4_OUT_W = 17;

  // Feedback delay depth, equal to the butterfly span of stage 4.
  localparam int S4_DLY   = 2;

  // Counter widths derived from the constants above.
  localparam int CNT_W    = $clog2(FFT_N);
  localparam int FLUSH_W  = $clog2(S4_DLY + 1);

  // Position of a sample inside its 4-sample group (cnt[1:0]).
  // The two low slots push inputs and emit the previous group's differences.
  // The two high slots emit sums and push differences.
  typedef enum logic [1:0] {
    SLOT_DIFF0 = 2'b00,
    SLOT_DIFF1 = 2'b01,
    SLOT_SUM0  = 2'b10,
    SLOT_SUM1  = 2'b11
  } slot_e;

endpackage

// File: rtl/fft_stage4_bf2.sv
// Combinational radix-2 butterfly: sign-extends the new sample to the output
// width and forms head+new and head-new with one bit of growth headroom.
module fft_stage4_bf2 #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 17
) (
  input  logic signed [OUT_W-1:0] a_r,
  input  logic signed [OUT_W-1:0] a_i,
  input  logic signed [IN_W-1:0]  b_r,
  input  logic signed [IN_W-1:0]  b_i,
  output logic signed [OUT_W-1:0] ext_r,
  output logic signed [OUT_W-1:0] ext_i,
  output logic signed [OUT_W-1:0] sum_r,
  output logic signed [OUT_W-1:0] sum_i,
  output logic signed [OUT_W-1:0] diff_r,
  output logic signed [OUT_W-1:0] diff_i
);

  // Sign extension of the incoming sample.
  assign ext_r = {{(OUT_W-IN_W){b_r[IN_W-1]}}, b_r};
  assign ext_i = {{(OUT_W-IN_W){b_i[IN_W-1]}}, b_i};

  // Butterfly; no rounding or saturation, the extra bit absorbs the growth.
  assign sum_r  = a_r + ext_r;
  assign sum_i  = a_i + ext_i;
  assign diff_r = a_r - ext_r;
  assign diff_i = a_i - ext_i;

endmodule

// File: rtl/fft_stage4.sv
// Stage 4 of the 32-point pipelined SDF DIF FFT: 2-deep feedback delay line,
// span-2 butterfly and a trivial W4 twiddle (1 or -j).
// valid_i qualifies one input sample per clock and is frame-contiguous; valid_o
// qualifies one output sample per clock. There is no backpressure: the stage
// always accepts and always emits.
module fft_stage4
  import fft_stage4_pkg::*;
#(
  parameter int IN_W  = S3_OUT_W,
  parameter int OUT_W = S4_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic signed [IN_W-1:0]  data_in_r,
  input  logic signed [IN_W-1:0]  data_in_i,
  output logic                    valid_o,
  output logic signed [OUT_W-1:0] data_out_r,
  output logic signed [OUT_W-1:0] data_out_i
);

  localparam int DLY = S4_DLY;

  logic [CNT_W-1:0]        cnt;
  logic [FLUSH_W-1:0]      flush;
  logic [DLY-1:0]          run_sr;
  logic                    run;
  logic                    last_flush;
  slot_e                   slot;

  logic signed [IN_W-1:0]  in_r;
  logic signed [IN_W-1:0]  in_i;
  logic signed [OUT_W-1:0] dl_r [DLY];
  logic signed [OUT_W-1:0] dl_i [DLY];
  logic signed [OUT_W-1:0] head_r;
  logic signed [OUT_W-1:0] head_i;
  logic signed [OUT_W-1:0] ext_r;
  logic signed [OUT_W-1:0] ext_i;
  logic signed [OUT_W-1:0] sum_r;
  logic signed [OUT_W-1:0] sum_i;
  logic signed [OUT_W-1:0] diff_r;
  logic signed [OUT_W-1:0] diff_i;
  logic signed [OUT_W-1:0] push_r;
  logic signed [OUT_W-1:0] push_i;
  logic signed [OUT_W-1:0] res_r;
  logic signed [OUT_W-1:0] res_i;

  // The stage advances on real samples and on the drain cycles after a stream.
  assign run        = valid_i | (flush != '0);
  assign last_flush = !valid_i && (flush == FLUSH_W'(1));
  assign slot       = slot_e'(cnt[1:0]);

  // Drain cycles feed zeros so the last two differences come out cleanly.
  assign in_r   = valid_i ? data_in_r : '0;
  assign in_i   = valid_i ? data_in_i : '0;
  assign head_r = dl_r[DLY-1];
  assign head_i = dl_i[DLY-1];

  fft_stage4_bf2 #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_bf2 (
    .a_r    (head_r),
    .a_i    (head_i),
    .b_r    (in_r),
    .b_i    (in_i),
    .ext_r  (ext_r),
    .ext_i  (ext_i),
    .sum_r  (sum_r),
    .sum_i  (sum_i),
    .diff_r (diff_r),
    .diff_i (diff_i)
  );

  // Select what enters the delay line and what leaves the stage this cycle.
  always_comb begin
    push_r = ext_r;
    push_i = ext_i;
    res_r  = head_r;
    res_i  = head_i;
    case (slot)
      SLOT_DIFF0: begin
        res_r = head_r;
        res_i = head_i;
      end
      SLOT_DIFF1: begin
        // (a+jb)*(-j) = b - ja; |diff| < 2^16 so the negation cannot wrap.
        res_r = head_i;
        res_i = -head_r;
      end
      SLOT_SUM0, SLOT_SUM1: begin
        res_r  = sum_r;
        res_i  = sum_i;
        push_r = diff_r;
        push_i = diff_i;
      end
      default: begin
        res_r = head_r;
        res_i = head_i;
      end
    endcase
  end

  // Sample counter, drain counter and output qualifier.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      flush   <= '0;
      run_sr  <= '0;
      valid_o <= 1'b0;
    end else begin
      // Held at DLY while samples arrive, then counts down after the stream ends.
      if (valid_i) begin
        flush <= FLUSH_W'(DLY);
      end else if (flush != '0) begin
        flush <= flush - FLUSH_W'(1);
      end
      // The final drain cycle re-aligns cnt to 0, also after a truncated frame.
      if (run) begin
        cnt <= last_flush ? '0 : cnt + CNT_W'(1);
      end
      run_sr  <= {run_sr[DLY-2:0], run};
      valid_o <= run & run_sr[DLY-1];
    end
  end

  // Feedback delay line: shifts one entry per run cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DLY; k++) begin
        dl_r[k] <= '0;
        dl_i[k] <= '0;
      end
    end else if (run) begin
      dl_r[0] <= push_r;
      dl_i[0] <= push_i;
      for (int k = 1; k < DLY; k++) begin
        dl_r[k] <= dl_r[k-1];
        dl_i[k] <= dl_i[k-1];
      end
    end
  end

  // Registered outputs; they hold their last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r <= '0;
      data_out_i <= '0;
    end else if (run) begin
      data_out_r <= res_r;
      data_out_i <= res_i;
    end
  end

endmodule

// File: tb/tb_fft_stage4.sv
// Bench for fft_stage4: table of {input, expected output} records plus a
// reference group model, with an expected-output queue checked on valid_o.
module tb_fft_stage4;

  localparam int IN_W  = 16;
  localparam int OUT_W = 17;
  localparam int NGRP  = 7;

  // ---------------- clock / reset / DUT ----------------
  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid_i;
  logic signed [IN_W-1:0]  data_in_r;
  logic signed [IN_W-1:0]  data_in_i;
  logic                    valid_o;
  logic signed [OUT_W-1:0] data_out_r;
  logic signed [OUT_W-1:0] data_out_i;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fft_stage4 dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .valid_o    (valid_o),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i)
  );

  // ---------------- vector table ----------------
  // Record k: input sample k of a group and the output at stream position k
  // (group output order is sum0, sum1, diff0, diff1*(-j)).
  typedef struct packed {
    logic signed [IN_W-1:0]  in_r;
    logic signed [IN_W-1:0]  in_i;
    logic signed [OUT_W-1:0] exp_r;
    logic signed [OUT_W-1:0] exp_i;
  } vec_t;

  vec_t tbl [NGRP*4];
  int   nvec = 0;

  // ---------------- scoreboard state ----------------
  logic [2*OUT_W-1:0] exp_q[$];
  logic [2*OUT_W-1:0] mon_e;
  int n_vec = 0;
  int n_err = 0;
  int vcount;
  int first_out;
  int first_in;
  bit sb_en = 1'b0;

  int gx_r[4];
  int gx_i[4];
  int ge_r[4];
  int ge_i[4];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int xr, input int xi, input int er, input int ei);
    tbl[nvec].in_r  = IN_W'(xr);
    tbl[nvec].in_i  = IN_W'(xi);
    tbl[nvec].exp_r = OUT_W'(er);
    tbl[nvec].exp_i = OUT_W'(ei);
    nvec++;
  endtask

  // Reference DIF span-2 butterfly on one 4-sample group.
  function automatic void model_group();
    ge_r[0] = gx_r[0] + gx_r[2];
    ge_i[0] = gx_i[0] + gx_i[2];
    ge_r[1] = gx_r[1] + gx_r[3];
    ge_i[1] = gx_i[1] + gx_i[3];
    ge_r[2] = gx_r[0] - gx_r[2];
    ge_i[2] = gx_i[0] - gx_i[2];
    ge_r[3] = gx_i[1] - gx_i[3];
    ge_i[3] = -(gx_r[1] - gx_r[3]);
  endfunction

  // mode 0: impulse frame, 1: table groups, 2: ramp, 3: random.
  task automatic build_group(input int mode, input int g);
    int base;
    if (mode <= 1) begin
      base = (mode == 0) ? ((g == 0) ? 0 : 4) : (g % NGRP) * 4;
      for (int j = 0; j < 4; j++) begin
        gx_r[j] = int'(tbl[base+j].in_r);
        gx_i[j] = int'(tbl[base+j].in_i);
        ge_r[j] = int'(tbl[base+j].exp_r);
        ge_i[j] = int'(tbl[base+j].exp_i);
      end
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (mode == 2) begin
          gx_r[j] = 4 * g + j;
          gx_i[j] = 0;
        end else begin
          gx_r[j] = int'($urandom_range(65535, 0)) - 32768;
          gx_i[j] = int'($urandom_range(65535, 0)) - 32768;
        end
      end
      model_group();
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input int r, input int i);
    @(negedge clk);
    valid_i   = v;
    data_in_r = IN_W'(r);
    data_in_i = IN_W'(i);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && valid_o) begin
        vcount++;
        if (first_out < 0) first_out = cyc;
        if (sb_en) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL out_unexpected: got (%0d,%0d) expected no output",
                     data_out_r, data_out_i);
          end else begin
            mon_e = exp_q.pop_front();
            if ({data_out_r, data_out_i} !== mon_e) begin
              n_err++;
              $display("FAIL out_sample: got (%0d,%0d) expected (%0d,%0d)",
                       data_out_r, data_out_i,
                       $signed(mon_e[2*OUT_W-1:OUT_W]), $signed(mon_e[OUT_W-1:0]));
            end
          end
        end
      end
    end
  endtask

  // One contiguous stream of nfr frames; frame 0 uses m0, later frames m1.
  task automatic run_stream(input int nfr, input int m0, input int m1);
    vcount    = 0;
    first_out = -1;
    sb_en     = 1'b1;
    for (int f = 0; f < nfr; f++) begin
      for (int g = 0; g < 8; g++) begin
        build_group((f == 0) ? m0 : m1, g);
        for (int j = 0; j < 4; j++)
          exp_q.push_back({OUT_W'(ge_r[j]), OUT_W'(ge_i[j])});
        for (int j = 0; j < 4; j++) begin
          drive(1'b1, gx_r[j], gx_i[j]);
          if (f == 0 && g == 0 && j == 0) first_in = cyc;
        end
      end
    end
    idle(8);
    check("valid_count", vcount, 32 * nfr);
    check("latency", first_out - (first_in + 1), 2);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst       = 1'b1;
    valid_i   = 1'b0;
    data_in_r = '0;
    data_in_i = '0;

    // impulse group, zero group, ramp groups, extremes, mixed, signed corners
    add_vec(1, 0, 1, 0);   add_vec(0, 0, 0, 0);   add_vec(0, 0, 1, 0);   add_vec(0, 0, 0, 0);
    add_vec(0, 0, 0, 0);   add_vec(0, 0, 0, 0);   add_vec(0, 0, 0, 0);   add_vec(0, 0, 0, 0);
    add_vec(0, 0, 2, 0);   add_vec(1, 0, 4, 0);   add_vec(2, 0, -2, 0);  add_vec(3, 0, 0, 2);
    add_vec(4, 0, 10, 0);  add_vec(5, 0, 12, 0);  add_vec(6, 0, -2, 0);  add_vec(7, 0, 0, 2);
    add_vec(32767, -32768, 65534, -65536);  add_vec(32767, -32768, 65534, -65536);
    add_vec(32767, -32768, 0, 0);           add_vec(32767, -32768, 0, 0);
    add_vec(100, -50, 120, -10);  add_vec(-300, 7, -295, -2);
    add_vec(20, 40, 80, -90);     add_vec(5, -9, 16, 305);
    add_vec(-32768, 32767, -1, 65534);  add_vec(32767, -32768, -1, -65536);
    add_vec(32767, 32767, -65535, 0);   add_vec(-32768, -32768, 0, -65535);

    fork
      monitor();
    join_none

    // power-on reset state
    repeat (3) @(negedge clk);
    check("reset_valid_o", valid_o, 0);
    check("reset_out_r", data_out_r, 0);
    check("reset_out_i", data_out_i, 0);
    rst = 1'b0;
    idle(2);

    run_stream(1, 0, 0);   // impulse
    run_stream(1, 1, 1);   // table groups
    run_stream(1, 2, 2);   // ramp
    run_stream(2, 1, 3);   // back-to-back: table frame then random frame
    run_stream(1, 3, 3);   // random

    // reset while idle, outputs holding a nonzero result
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_reset_valid_o", valid_o, 0);
    check("idle_reset_out_r", data_out_r, 0);
    check("idle_reset_out_i", data_out_i, 0);
    rst = 1'b0;
    idle(2);

    // reset asserted at sample 10 of a ramp frame
    sb_en = 1'b0;
    for (int k = 0; k < 10; k++) drive(1'b1, k, 0);
    @(negedge clk);
    rst       = 1'b1;
    valid_i   = 1'b1;
    data_in_r = IN_W'(10);
    data_in_i = '0;
    @(negedge clk);
    check("midrst_valid_o", valid_o, 0);
    check("midrst_out_r", data_out_r, 0);
    check("midrst_out_i", data_out_i, 0);
    rst     = 1'b0;
    valid_i = 1'b0;
    exp_q.delete();
    idle(4);
    run_stream(1, 0, 0);

    // valid_i dropped mid-frame: 10 samples plus 2 drain cycles
    sb_en  = 1'b0;
    vcount = 0;
    for (int k = 0; k < 10; k++) drive(1'b1, k + 1, 3);
    idle(8);
    check("drop_valid_count", vcount, 10);
    run_stream(1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
